perip_bus: RTL and testbench

//  Parametrised N-slave peripheral interconnect between the core's MEM stage and the memory-mapped

---
 rtl/perip_bus_pkg.sv | 28 ++
 rtl/perip_bus_addr_dec.sv | 47 ++++
 rtl/perip_bus.sv | 211 +++++++++++++++++++++
 tb/tb_perip_bus.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perip_bus_pkg.sv
// ---------------------------------------------------------------------------
// perip_bus_pkg
// Shared definitions for the peripheral interconnect: data-bus width and
// zero constant, wait-counter width, FSM state encoding and a helper that
// sizes the slave-select index.
// Optional feature macro used by perip_bus: PERIP_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package perip_bus_pkg;

  localparam int                DATA_W    = 32;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  // Width of the BUSY wait counter; TIMEOUT values above 2**TMO_W are
  // truncated to this width.
  localparam int TMO_W = 8;

  typedef enum logic [1:0] {
    PB_IDLE = 2'd0,
    PB_BUSY = 2'd1,
    PB_RESP = 2'd2
  } pb_state_e;

  // A single-slave build still needs a 1-bit select index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : perip_bus_pkg

// File: rtl/perip_bus_addr_dec.sv
// ---------------------------------------------------------------------------
// perip_bus_addr_dec
// Combinational N-way address window compare with lowest-index priority.
//   mem_addr  in   absolute byte address
//   hit       out  address falls inside at least one enabled window
//   sel       out  index of the lowest-numbered matching window
//   offset    out  mem_addr - base of the selected window
// A window i matches when (mem_addr - base_i) < size_i using 32-bit unsigned
// arithmetic: addresses below the base wrap to a large offset and miss, and
// a window ending exactly at 2**32 never needs a 33-bit end address.
// ---------------------------------------------------------------------------
module perip_bus_addr_dec
  import perip_bus_pkg::*;
#(
  parameter int                N_SLV    = 4,
  parameter logic [N_SLV*32-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*32-1:0] SLV_SIZE = '0,
  localparam int               SEL_W    = sel_width(N_SLV)
) (
  input  logic [DATA_W-1:0] mem_addr,
  output logic              hit,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] offset
);

  logic [DATA_W-1:0] off_i;

  // Scan from the highest index down so the lowest matching index is the
  // last one written and therefore wins on overlapping windows.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so
    // no path leaves a value unassigned and no latch is inferred.
    hit    = 1'b0;
    sel    = '0;
    offset = DATA_ZERO;
    off_i  = DATA_ZERO;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      off_i = mem_addr - SLV_BASE[32*i +: 32];
      if ((SLV_SIZE[32*i +: 32] != 32'h0) && (off_i < SLV_SIZE[32*i +: 32])) begin
        hit    = 1'b1;
        sel    = SEL_W'(i);
        offset = off_i;
      end
    end
  end

endmodule : perip_bus_addr_dec

// File: rtl/perip_bus.sv
// ---------------------------------------------------------------------------
// perip_bus
// N-slave peripheral interconnect between the core MEM stage and the
// memory-mapped peripherals. Decodes mem_addr into one of N_SLV windows,
// forwards a slave-relative offset, waits for the selected slave's ready and
// returns a registered one-cycle response.
//   clk, rst                  clock, synchronous active-high reset
//   mem_req/rw/addr/wdata     core request (sampled in IDLE only)
//   mem_rdata/ready/err       registered response, valid for one cycle
//   slv_ena                   one-hot select, high for the whole BUSY phase
//   slv_rw/addr/wdata         latched request with addr made slave-relative
//   slv_rdata/slv_ready       per-slave read data and done flags
// Optional feature: define PERIP_TIMEOUT_EN to abort an access with mem_err
// after TIMEOUT BUSY cycles without a ready from the selected slave. Without
// it BUSY waits indefinitely and mem_err flags unmapped addresses only.
// Timing: request sampled in cycle 0 -> slv_ena in cycle 1 -> mem_ready in
// cycle 2 at the earliest; unmapped -> mem_ready in cycle 1.
// ---------------------------------------------------------------------------
module perip_bus
  import perip_bus_pkg::*;
#(
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*32-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*32-1:0] SLV_SIZE = '0,
  parameter int                  TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_req,
  input  logic                mem_rw,
  input  logic [DATA_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_ready,
  output logic                mem_err,
  output logic [N_SLV-1:0]    slv_ena,
  output logic                slv_rw,
  output logic [DATA_W-1:0]   slv_addr,
  output logic [DATA_W-1:0]   slv_wdata,
  input  logic [N_SLV*32-1:0] slv_rdata,
  input  logic [N_SLV-1:0]    slv_ready
);

  localparam int SEL_W = sel_width(N_SLV);

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic              dec_hit;
  logic [SEL_W-1:0]  dec_sel;
  logic [DATA_W-1:0] dec_offset;
  logic [N_SLV-1:0]  dec_oh;

  perip_bus_addr_dec #(
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_SIZE (SLV_SIZE)
  ) u_addr_dec (
    .mem_addr (mem_addr),
    .hit      (dec_hit),
    .sel      (dec_sel),
    .offset   (dec_offset)
  );

  always_comb begin
    dec_oh = '0;
    for (int i = 0; i < N_SLV; i++) begin
      dec_oh[i] = dec_hit && (dec_sel == SEL_W'(i));
    end
  end

  // -------------------------------------------------------------------------
  // Selected-slave return path. slv_ena_q is one-hot during BUSY, so masking
  // with it both picks the selected slave and ignores every other ready bit.
  // -------------------------------------------------------------------------
  logic [N_SLV-1:0]  slv_ena_q, slv_ena_d;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;

  always_comb begin
    sel_ready = |(slv_ena_q & slv_ready);
    sel_rdata = DATA_ZERO;
    for (int i = 0; i < N_SLV; i++) begin
      sel_rdata = sel_rdata | (slv_rdata[32*i +: 32] & {DATA_W{slv_ena_q[i]}});
    end
  end

  // -------------------------------------------------------------------------
  // FSM and registered outputs
  // -------------------------------------------------------------------------
  pb_state_e         state_q, state_d;
  logic              slv_rw_q, slv_rw_d;
  logic [DATA_W-1:0] slv_addr_q, slv_addr_d;
  logic [DATA_W-1:0] slv_wdata_q, slv_wdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic              mem_err_q, mem_err_d;

`ifdef PERIP_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_comb begin
    state_d     = state_q;
    slv_ena_d   = slv_ena_q;
    slv_rw_d    = slv_rw_q;
    slv_addr_d  = slv_addr_q;
    slv_wdata_d = slv_wdata_q;
    // Response fields are single-cycle: zero unless entering RESP.
    mem_rdata_d = DATA_ZERO;
    mem_ready_d = 1'b0;
    mem_err_d   = 1'b0;
`ifdef PERIP_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    case (state_q)
      PB_IDLE: begin
        if (mem_req) begin
          if (dec_hit) begin
            state_d     = PB_BUSY;
            slv_ena_d   = dec_oh;
            slv_rw_d    = mem_rw;
            slv_addr_d  = dec_offset;
            slv_wdata_d = mem_wdata;
`ifdef PERIP_TIMEOUT_EN
            wait_cnt_d  = '0;
`endif
          end else begin
            state_d     = PB_RESP;
            mem_ready_d = 1'b1;
            mem_err_d   = 1'b1;
          end
        end
      end

      PB_BUSY: begin
        // A ready in the limit cycle is checked first, so it completes
        // normally instead of timing out.
        if (sel_ready) begin
          state_d     = PB_RESP;
          slv_ena_d   = '0;
          mem_ready_d = 1'b1;
          mem_rdata_d = slv_rw_q ? DATA_ZERO : sel_rdata;
        end
`ifdef PERIP_TIMEOUT_EN
        else if (wait_cnt_q == TMO_LAST) begin
          state_d     = PB_RESP;
          slv_ena_d   = '0;
          mem_ready_d = 1'b1;
          mem_err_d   = 1'b1;
        end else begin
          wait_cnt_d  = wait_cnt_q + 1'b1;
        end
`endif
      end

      PB_RESP: begin
        state_d = PB_IDLE;
      end

      default: begin
        state_d   = PB_IDLE;
        slv_ena_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PB_IDLE;
      slv_ena_q   <= '0;
      slv_rw_q    <= 1'b0;
      slv_addr_q  <= DATA_ZERO;
      slv_wdata_q <= DATA_ZERO;
      mem_rdata_q <= DATA_ZERO;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
`ifdef PERIP_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every flop see the pre-edge
      // value of the others, independent of statement order.
      state_q     <= state_d;
      slv_ena_q   <= slv_ena_d;
      slv_rw_q    <= slv_rw_d;
      slv_addr_q  <= slv_addr_d;
      slv_wdata_q <= slv_wdata_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
`ifdef PERIP_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign slv_ena   = slv_ena_q;
  assign slv_rw    = slv_rw_q;
  assign slv_addr  = slv_addr_q;
  assign slv_wdata = slv_wdata_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign mem_err   = mem_err_q;

endmodule : perip_bus

// File: tb/tb_perip_bus.sv
// ---------------------------------------------------------------------------
// tb_perip_bus
// Directed bench for perip_bus with four windows:
//   0: 0x0000_0000 / 0x8000   1: 0x1000_0000 / 0x1000
//   2: 0x2000_0000 / 0x10     3: 0xFFFF_FFF0 / 0x10
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_perip_bus;

  localparam int N_SLV = 4;
  localparam logic [N_SLV*32-1:0] BASES =
    {32'hFFFF_FFF0, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [N_SLV*32-1:0] SIZES =
    {32'h0000_0010, 32'h0000_0010, 32'h0000_1000, 32'h0000_8000};

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                mem_req = 1'b0;
  logic                mem_rw = 1'b0;
  logic [31:0]         mem_addr = '0;
  logic [31:0]         mem_wdata = '0;
  logic [31:0]         mem_rdata;
  logic                mem_ready;
  logic                mem_err;
  logic [N_SLV-1:0]    slv_ena;
  logic                slv_rw;
  logic [31:0]         slv_addr;
  logic [31:0]         slv_wdata;
  logic [N_SLV*32-1:0] slv_rdata = '0;
  logic [N_SLV-1:0]    slv_ready = '0;

  perip_bus #(
    .N_SLV    (N_SLV),
    .SLV_BASE (BASES),
    .SLV_SIZE (SIZES),
    .TIMEOUT  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_err   (mem_err),
    .slv_ena   (slv_ena),
    .slv_rw    (slv_rw),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata),
    .slv_ready (slv_ready)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Results of the latest access.
  int          r_ready_cyc;   // cycles after the request cycle; -1 = no pulse
  int          r_ready_at;    // global cycle of the mem_ready pulse
  int          r_ena_cyc;     // cycles with any slv_ena bit high
  logic [3:0]  r_sena;
  logic [31:0] r_saddr;
  logic        r_srw;
  logic [31:0] r_swdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [3:0]  r_ena_at_ready;

  // One core access plus a slave model: the selected slave raises ready in
  // its (wait_n+1)-th enabled cycle; unselected slaves hold ready high and
  // return a background pattern so a bad select shows up.
  task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wait_n, input logic [31:0] rd, input int budget);
    @(negedge clk);
    check("idle_ready_low", {31'b0, mem_ready}, 32'h0);
    check("idle_rdata_zero", mem_rdata, 32'h0);
    mem_req   = 1'b1;
    mem_rw    = rw;
    mem_addr  = addr;
    mem_wdata = wdata;
    r_ready_cyc = -1; r_ready_at = -1; r_ena_cyc = 0;
    r_sena = '0; r_saddr = '0; r_srw = 1'b0; r_swdata = '0;
    r_rdata = '0; r_err = 1'b0; r_ena_at_ready = '0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (slv_ena != '0) begin
        if (r_ena_cyc == 0) begin
          r_sena = slv_ena; r_saddr = slv_addr; r_srw = slv_rw; r_swdata = slv_wdata;
        end
        r_ena_cyc++;
      end
      if (mem_ready) begin
        r_ready_cyc    = cyc;
        r_ready_at     = cycle_cnt;
        r_rdata        = mem_rdata;
        r_err          = mem_err;
        r_ena_at_ready = slv_ena;
        mem_req        = 1'b0;
        slv_ready      = '0;
        break;
      end
      for (int i = 0; i < N_SLV; i++)
        slv_rdata[32*i +: 32] = slv_ena[i] ? rd : (32'hA5A5_0000 | 32'(i));
      slv_ready = ((slv_ena != '0) && (r_ena_cyc > wait_n)) ? 4'hF : ~slv_ena;
    end
  endtask

  int prev_ready_at;
  int pulses;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_slv_ena", {28'b0, slv_ena}, 32'h0);
    check("rst_slv_rw", {31'b0, slv_rw}, 32'h0);
    check("rst_slv_addr", slv_addr, 32'h0);
    check("rst_slv_wdata", slv_wdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
    check("rst_mem_err", {31'b0, mem_err}, 32'h0);
    rst = 1'b0;

    // ---------------- 1: read slave1, immediate ready ----------------
    access(1'b0, 32'h1000_0004, 32'h0, 0, 32'hDEAD_BEEF, 20);
    check("t1_ready_cyc", r_ready_cyc, 2);
    check("t1_ena_cyc", r_ena_cyc, 1);
    check("t1_sena", {28'b0, r_sena}, 32'h2);
    check("t1_saddr", r_saddr, 32'h4);
    check("t1_srw", {31'b0, r_srw}, 32'h0);
    check("t1_rdata", r_rdata, 32'hDEAD_BEEF);
    check("t1_err", {31'b0, r_err}, 32'h0);
    check("t1_ena_in_resp", {28'b0, r_ena_at_ready}, 32'h0);

    // ---------------- 2: write slave2, 5 wait states ----------------
    access(1'b1, 32'h2000_0008, 32'h55, 5, 32'h1234_5678, 20);
    check("t2_ready_cyc", r_ready_cyc, 7);
    check("t2_ena_cyc", r_ena_cyc, 6);
    check("t2_sena", {28'b0, r_sena}, 32'h4);
    check("t2_saddr", r_saddr, 32'h8);
    check("t2_srw", {31'b0, r_srw}, 32'h1);
    check("t2_swdata", r_swdata, 32'h55);
    check("t2_rdata", r_rdata, 32'h0);
    check("t2_err", {31'b0, r_err}, 32'h0);

    // ---------------- 3: unmapped read ----------------
    access(1'b0, 32'h3000_0000, 32'h0, 0, 32'h1111_1111, 20);
    check("t3_ready_cyc", r_ready_cyc, 1);
    check("t3_ena_cyc", r_ena_cyc, 0);
    check("t3_err", {31'b0, r_err}, 32'h1);
    check("t3_rdata", r_rdata, 32'h0);

    // ---------------- 4: window boundaries ----------------
    access(1'b0, 32'hFFFF_FFFC, 32'h0, 0, 32'hCAFE_F00D, 20);
    check("t4_top_sena", {28'b0, r_sena}, 32'h8);
    check("t4_top_saddr", r_saddr, 32'hC);
    check("t4_top_rdata", r_rdata, 32'hCAFE_F00D);
    check("t4_top_ready_cyc", r_ready_cyc, 2);
    prev_ready_at = r_ready_at;

    access(1'b0, 32'h1000_0FFF, 32'h0, 0, 32'h0BAD_CAFE, 20);
    check("t4_s1_last_sena", {28'b0, r_sena}, 32'h2);
    check("t4_s1_last_saddr", r_saddr, 32'hFFF);
    check("t4_s1_last_rdata", r_rdata, 32'h0BAD_CAFE);
    check("t4_back_to_back", r_ready_at - prev_ready_at, 3);

    access(1'b0, 32'h0000_8000, 32'h0, 0, 32'h2222_2222, 20);
    check("t4_s0_end_err", {31'b0, r_err}, 32'h1);
    check("t4_s0_end_ready_cyc", r_ready_cyc, 1);
    check("t4_s0_end_ena", r_ena_cyc, 0);

    access(1'b0, 32'h0FFF_FFFF, 32'h0, 0, 32'h3333_3333, 20);
    check("t4_below_s1_err", {31'b0, r_err}, 32'h1);

    access(1'b0, 32'h0000_7FFC, 32'h0, 2, 32'h0F0F_0F0F, 20);
    check("t4_s0_last_sena", {28'b0, r_sena}, 32'h1);
    check("t4_s0_last_saddr", r_saddr, 32'h7FFC);
    check("t4_s0_last_ready_cyc", r_ready_cyc, 4);
    check("t4_s0_last_rdata", r_rdata, 32'h0F0F_0F0F);

    // ---------------- 5: unresponsive slave ----------------
`ifdef PERIP_TIMEOUT_EN
    access(1'b0, 32'h0000_0100, 32'h0, 15, 32'h7777_7777, 40);
    check("t5_limit_ready_cyc", r_ready_cyc, 17);
    check("t5_limit_err", {31'b0, r_err}, 32'h0);
    check("t5_limit_rdata", r_rdata, 32'h7777_7777);

    access(1'b0, 32'h0000_0100, 32'h0, 1000, 32'h8888_8888, 40);
    check("t5_tmo_ready_cyc", r_ready_cyc, 17);
    check("t5_tmo_ena_cyc", r_ena_cyc, 16);
    check("t5_tmo_err", {31'b0, r_err}, 32'h1);
    check("t5_tmo_rdata", r_rdata, 32'h0);

    access(1'b1, 32'h0000_0100, 32'h0000_ABCD, 1000, 32'h8888_8888, 3);
    check("t6_busy_before_rst", r_ena_cyc, 3);
`else
    access(1'b1, 32'h0000_0100, 32'h0000_ABCD, 5000, 32'h8888_8888, 1000);
    check("t5_no_ready", r_ready_cyc, -1);
    check("t5_busy_held", r_ena_cyc, 1000);
`endif

    // ---------------- 6: reset while BUSY ----------------
    check("t6_ena_before_rst", {28'b0, slv_ena}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_ena_dropped", {28'b0, slv_ena}, 32'h0);
    check("t6_no_ready", {31'b0, mem_ready}, 32'h0);
    check("t6_addr_cleared", slv_addr, 32'h0);
    check("t6_wdata_cleared", slv_wdata, 32'h0);
    check("t6_rw_cleared", {31'b0, slv_rw}, 32'h0);
    mem_req   = 1'b0;
    slv_ready = '0;
    rst       = 1'b0;
    pulses    = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_ready || (slv_ena != '0)) pulses++;
    end
    check("t6_quiet_after_rst", pulses, 0);

    access(1'b0, 32'h2000_0004, 32'h0, 1, 32'h4444_5555, 20);
    check("t6_recover_ready_cyc", r_ready_cyc, 3);
    check("t6_recover_saddr", r_saddr, 32'h4);
    check("t6_recover_rdata", r_rdata, 32'h4444_5555);
    check("t6_recover_err", {31'b0, r_err}, 32'h0);

    @(negedge clk);
    check("final_ready_low", {31'b0, mem_ready}, 32'h0);
    check("final_rdata_zero", mem_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_perip_bus
